// File: rtl/shift_feeder.sv
// Byte feeder for an external right-shift register: FIFO-buffers bytes and
// issues load/data so each byte leaves LSB-first on the register's bit 0 without gaps.
module shift_feeder #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     sr_load,
  output logic [WIDTH-1:0]         sr_data,
  output logic                     bit_valid,
  output logic [$clog2(WIDTH)-1:0] bit_index,
  output logic                     frame_start,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(WIDTH);
  localparam int LAST = WIDTH - 1;
  localparam logic [AW:0]   FULL_LEVEL = DEPTH[AW:0];
  localparam logic [AW:0]   PTR_ONE    = {{AW{1'b0}}, 1'b1};
  localparam logic [IW-1:0] LAST_BIT   = LAST[IW-1:0];
  localparam logic [IW-1:0] CNT_ONE    = {{(IW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r, rd_ptr_r;
  logic [AW:0]      level_s;
  logic             empty_s, full_s, push_s, pop_s;
  state_t           state_r, state_nx_s;
  logic [IW-1:0]    bit_cnt_r, bit_cnt_nx_s;
  logic             sr_load_s, bit_valid_s;

  // Reset is folded into empty so nothing is loaded or presented while it is held.
  assign level_s = wr_ptr_r - rd_ptr_r;
  assign empty_s = reset || (level_s == {(AW+1){1'b0}});
  assign full_s  = (level_s == FULL_LEVEL);
  assign push_s  = in_valid && in_ready;
  assign pop_s   = sr_load_s;

  assign in_ready    = !full_s && !reset;
  assign level       = reset ? {(AW+1){1'b0}} : level_s;
  assign sr_data     = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];
  assign sr_load     = sr_load_s;
  assign bit_valid   = bit_valid_s;
  assign bit_index   = bit_valid_s ? bit_cnt_r : {IW{1'b0}};
  assign frame_start = bit_valid_s && (bit_cnt_r == {IW{1'b0}});

  // FIFO storage write port
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= in_data;
    end
  end

  // FIFO pointers; the extra MSB distinguishes full from empty
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
    end
  end

  // FSM state and bit counter register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= IDLE;
      bit_cnt_r <= {IW{1'b0}};
    end else begin
      state_r   <= state_nx_s;
      bit_cnt_r <= bit_cnt_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s   = state_r;
    bit_cnt_nx_s = bit_cnt_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          state_nx_s   = SHIFT;
          bit_cnt_nx_s = {IW{1'b0}};
        end else begin
          state_nx_s   = IDLE;
        end
      end
      SHIFT: begin
        if (bit_cnt_r != LAST_BIT) begin
          bit_cnt_nx_s = bit_cnt_r + CNT_ONE;
        end else if (!empty_s) begin
          state_nx_s   = SHIFT;
          bit_cnt_nx_s = {IW{1'b0}};
        end else begin
          state_nx_s   = IDLE;
          bit_cnt_nx_s = {IW{1'b0}};
        end
      end
      default: begin
        state_nx_s   = IDLE;
        bit_cnt_nx_s = {IW{1'b0}};
      end
    endcase
  end

  // Output decode: load on idle-with-data or on the last bit of a byte
  always_comb begin
    sr_load_s   = 1'b0;
    bit_valid_s = 1'b0;
    case (state_r)
      IDLE: begin
        bit_valid_s = 1'b0;
        sr_load_s   = !empty_s;
      end
      SHIFT: begin
        bit_valid_s = !reset;
        if (bit_cnt_r == LAST_BIT) begin
          sr_load_s = !empty_s;
        end else begin
          sr_load_s = 1'b0;
        end
      end
      default: begin
        sr_load_s   = 1'b0;
        bit_valid_s = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_feeder.sv
// Bench for shift_feeder: attaches a model of the 8-bit right-shift register and
// compares every cycle against a queue-based reference of the feeder's behaviour.
module tb_shift_feeder;
  localparam int W = 8;
  localparam int D = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_ready, sr_load, bit_valid, frame_start;
  logic [W-1:0] sr_data;
  logic [2:0]   bit_index;
  logic [2:0]   level;
  logic [W-1:0] sr_q;

  int nvec = 0;
  int nerr = 0;

  // reference state
  logic [W-1:0] q[$];
  logic [W-1:0] outq[$];
  logic [W-1:0] cur, asm_b;
  int           cur_k = -1;
  int           max_level;
  bit           accepted;

  shift_feeder #(.WIDTH(W), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .sr_load(sr_load), .sr_data(sr_data),
    .bit_valid(bit_valid), .bit_index(bit_index), .frame_start(frame_start),
    .level(level)
  );

  always #5 clock = ~clock;

  // the downstream shift register this block feeds
  always @(posedge clock) begin
    if (reset)        sr_q <= '0;
    else if (sr_load) sr_q <= sr_data;
    else              sr_q <= sr_q >> 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // one clock cycle: drive, compare against the reference, advance the reference
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    logic e_ready, e_bv, e_load;
    @(negedge clock);
    in_valid = v; in_data = d; reset = r;
    #1;
    e_ready = !r && (q.size() < D);
    e_bv    = !r && (cur_k >= 0);
    e_load  = !r && (q.size() > 0) && (cur_k < 0 || cur_k == W-1);
    chk("in_ready", in_ready, e_ready);
    chk("level", level, r ? 0 : q.size());
    chk("bit_valid", bit_valid, e_bv);
    chk("bit_index", bit_index, e_bv ? cur_k : 0);
    chk("frame_start", frame_start, e_bv && cur_k == 0);
    chk("sr_load", sr_load, e_load);
    if (e_load) chk("sr_data", sr_data, q[0]);
    if (e_bv) begin
      chk("serial_bit", sr_q[0], cur[cur_k]);
      asm_b[cur_k] = sr_q[0];
      if (cur_k == W-1) outq.push_back(asm_b);
    end
    if (!r && int'(level) > max_level) max_level = int'(level);
    accepted = v && e_ready;
    if (r) begin
      q.delete();
      cur_k = -1;
    end else begin
      if (e_load) begin
        cur = q.pop_front();
        cur_k = 0;
      end else if (cur_k == W-1) cur_k = -1;
      else if (cur_k >= 0) cur_k++;
      if (accepted) q.push_back(d);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
  endtask

  // idle until the observed bit_index equals k; the next step then sees k+1
  task automatic wait_idx(input int k);
    int i;
    for (i = 0; i < 40; i++) begin
      if (bit_valid && int'(bit_index) == k) break;
      step(1'b0, '0, 1'b0);
    end
    if (i == 40) chk("wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    step(1'b0, '0, 1'b1);
    step(1'b1, 8'h55, 1'b1);
    chk("reset_level", level, 3'd0);

    // single byte
    outq.delete();
    step(1'b1, 8'hA5, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("a5_load", {sr_load, sr_data}, {1'b1, 8'hA5});
    idle(10);
    chk("a5_idle", bit_valid, 1'b0);
    chk("a5_bytes", outq.size(), 1);
    if (outq.size() > 0) chk("a5_value", outq[0], 8'hA5);

    // back-to-back
    outq.delete();
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h80, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    idle(26);
    chk("b2b_bytes", outq.size(), 3);
    if (outq.size() == 3) chk("b2b_values", {outq[0], outq[1], outq[2]}, 24'h0180FF);

    // full FIFO, upstream holds each value until accepted
    outq.delete();
    max_level = 0;
    begin
      int val = 1;
      for (int i = 0; i < 100 && val <= 6; i++) begin
        step(1'b1, W'(val), 1'b0);
        if (accepted) val++;
      end
    end
    idle(60);
    chk("full_peak", max_level, D);
    chk("full_count", outq.size(), 6);
    for (int i = 0; i < outq.size() && i < 6; i++) chk("full_order", outq[i], i + 1);

    // simultaneous push and pop with one byte queued
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b0, '0, 1'b0);
    wait_idx(6);
    step(1'b1, 8'h33, 1'b0);
    chk("pushpop_level", level, 3'd1);
    idle(30);

    // late push during the last bit with an empty FIFO
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, '0, 1'b0);
    wait_idx(6);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, '0, 1'b0);
    chk("late_idle", {bit_valid, sr_load, sr_data}, {1'b0, 1'b1, 8'h3C});
    idle(12);

    // reset mid-byte with two bytes queued
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'h96, 1'b0);
    step(1'b1, 8'h69, 1'b0);
    wait_idx(2);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    chk("rst_mid", {bit_valid, level}, 4'd0);
    idle(15);
    outq.delete();
    step(1'b1, 8'hE7, 1'b0);
    idle(12);
    chk("rst_new", outq.size(), 1);
    if (outq.size() > 0) chk("rst_new_val", outq[0], 8'hE7);

    // randomized traffic with varying load and occasional reset
    for (int blk = 0; blk < 6; blk++) begin
      int pct = $urandom_range(5, 100);
      for (int i = 0; i < 500; i++) begin
        step($urandom_range(0, 99) < pct, W'($urandom), $urandom_range(0, 399) == 0);
      end
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
